// File: rtl/imem_boot_sequencer.sv
// imem_boot_sequencer: holds the core in reset, streams a program image
// into instruction memory from word 0, then releases the core to run.
// Optional macro BOOT_HALT_DETECT_EN: park the core when pc stops moving.
// Ports: clk, reset (async, active high); start + load_len request a load;
// s_valid/s_data/s_ready program stream; imem_we/imem_addr/imem_wdata
// memory write port; pc from core; cpu_reset to core; busy/running/halted
// status; err sticky bad-request flag. All outputs registered.
module imem_boot_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int HALT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       pc,
  output logic              cpu_reset,
  output logic              busy,
  output logic              running,
  output logic              halted,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_HALT
  } state_t;

  // DEPTH expressed in the load_len width (fits: one extra bit)
  localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_cnt;
  logic                r_s_ready;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [31:0]         r_imem_wdata;
  logic                r_cpu_reset;
  logic                r_busy;
  logic                r_running;
  logic                r_halted;
  logic                r_err;

  logic w_len_ok;
  logic w_go;
  logic w_hs;
  logic w_last;

  assign w_len_ok = (load_len != '0) && (load_len <= L_DEPTH);
  assign w_go     = start & w_len_ok;
  assign w_hs     = s_valid & r_s_ready;
  assign w_last   = (r_cnt + 1'b1) == r_len;

`ifdef BOOT_HALT_DETECT_EN
  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [SW-1:0] L_HALT = SW'(HALT_CYCLES);

  logic [31:0]   r_pc_prev;
  logic          r_pc_vld;
  logic [SW-1:0] r_stable;
  logic          w_pc_same;

  // r_pc_vld gates the first RUN cycle: no previous pc to compare yet
  assign w_pc_same = r_pc_vld && (pc == r_pc_prev);
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_s_ready    <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_reset  <= 1'b1;
      r_busy       <= 1'b0;
      r_running    <= 1'b0;
      r_halted     <= 1'b0;
      r_err        <= 1'b0;
`ifdef BOOT_HALT_DETECT_EN
      r_pc_prev    <= '0;
      r_pc_vld     <= 1'b0;
      r_stable     <= '0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          // ready rises one cycle into LOAD, drops with the last word
          r_imem_we <= w_hs;
          r_s_ready <= !(w_hs && w_last);
          if (w_hs) begin
            r_imem_addr  <= r_cnt[ADDR_W-1:0];
            r_imem_wdata <= s_data;
            r_cnt        <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          // last write lands this cycle with the core still in reset
          r_state     <= S_RUN;
          r_cpu_reset <= 1'b0;
          r_busy      <= 1'b0;
          r_running   <= 1'b1;
`ifdef BOOT_HALT_DETECT_EN
          r_pc_vld    <= 1'b0;
          r_stable    <= '0;
`endif
        end
        default: begin
          // IDLE, RUN and HALT share the start-request rule
          if (w_go) begin
            r_state     <= S_LOAD;
            r_len       <= load_len;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_s_ready   <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_running   <= 1'b0;
            r_halted    <= 1'b0;
          end else begin
            if (start) begin
              r_err <= 1'b1;
            end
`ifdef BOOT_HALT_DETECT_EN
            if (r_state == S_RUN) begin
              r_pc_prev <= pc;
              r_pc_vld  <= 1'b1;
              if (r_stable == L_HALT) begin
                r_state     <= S_HALT;
                r_cpu_reset <= 1'b1;
                r_running   <= 1'b0;
                r_halted    <= 1'b1;
              end else if (w_pc_same) begin
                r_stable <= r_stable + 1'b1;
              end else begin
                r_stable <= '0;
              end
            end
`endif
          end
        end
      endcase
    end
  end

  assign s_ready    = r_s_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign busy       = r_busy;
  assign running    = r_running;
  assign halted     = r_halted;
  assign err        = r_err;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// tb_imem_boot_sequencer: table-driven start checks, scoreboarded loads,
// halt detection (when BOOT_HALT_DETECT_EN is defined) and mid-load reset.
module tb_imem_boot_sequencer;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   load_len;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [31:0]   pc;
  logic          cpu_reset;
  logic          busy;
  logic          running;
  logic          halted;
  logic          err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [AW:0] len;
    logic        e_err;
    logic        e_busy;
    logic        e_rdy2;
  } vec_t;
  vec_t tbl[5];

  logic [31:0] prog[5];

  imem_boot_sequencer #(.ADDR_W(AW), .HALT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_len   (load_len),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .pc         (pc),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .running    (running),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard: every write seen on the memory port must match the queue
  always @(negedge clk) begin
    wr_t e;
    if (!reset && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr %0d data %h, expected addr %0d data %h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic rst_vals(input string nm);
    chk({nm, "_s_ready"}, 32'(s_ready), 0);
    chk({nm, "_imem_we"}, 32'(imem_we), 0);
    chk({nm, "_imem_addr"}, 32'(imem_addr), 0);
    chk({nm, "_imem_wdata"}, imem_wdata, 0);
    chk({nm, "_cpu_reset"}, 32'(cpu_reset), 1);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_running"}, 32'(running), 0);
    chk({nm, "_halted"}, 32'(halted), 0);
    chk({nm, "_err"}, 32'(err), 0);
  endtask

  // Full load; gap_len idle cycles are inserted once gap_at words are in.
  task automatic do_load(input logic [AW:0] len, input int gap_at,
                         input int gap_len, input int exp_lat,
                         input string nm, input int base);
    int lat;
    int w;
    int g;
    logic [AW-1:0] a;
    wr_t e;
    lat = 0;
    w = 0;
    g = 0;
    a = '0;
    start = 1'b1;
    load_len = len;
    tick();
    start = 1'b0;
    chk({nm, "_cpu_reset_held"}, 32'(cpu_reset), 1);
    chk({nm, "_busy"}, 32'(busy), 1);
    while (cpu_reset && lat < 200) begin
      if (w == gap_at && g < gap_len && s_ready) begin
        s_valid = 1'b0;
        g++;
      end else if (w < int'(len)) begin
        s_valid = 1'b1;
        s_data = prog[base + w];
        if (s_ready) begin
          e.addr = a;
          e.data = s_data;
          exp_q.push_back(e);
          a++;
          w++;
        end
      end else begin
        s_valid = 1'b0;
      end
      tick();
      lat++;
    end
    s_valid = 1'b0;
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_running"}, 32'(running), 1);
    chk({nm, "_busy_done"}, 32'(busy), 0);
    chk({nm, "_halted"}, 32'(halted), 0);
    chk({nm, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    int w;
    int lat;
    logic [AW-1:0] a;
    wr_t e;

    prog[0] = 32'h20080005;
    prog[1] = 32'h20090007;
    prog[2] = 32'h08000002;
    prog[3] = 32'hAC080004;
    prog[4] = 32'h1000FFFF;

    tbl[0] = '{len: 7'd0,   e_err: 1'b1, e_busy: 1'b0, e_rdy2: 1'b0};
    tbl[1] = '{len: 7'd65,  e_err: 1'b1, e_busy: 1'b0, e_rdy2: 1'b0};
    tbl[2] = '{len: 7'd1,   e_err: 1'b0, e_busy: 1'b1, e_rdy2: 1'b1};
    tbl[3] = '{len: 7'd127, e_err: 1'b1, e_busy: 1'b0, e_rdy2: 1'b0};
    tbl[4] = '{len: 7'd64,  e_err: 1'b0, e_busy: 1'b1, e_rdy2: 1'b1};

    reset = 1'b1;
    start = 1'b0;
    load_len = '0;
    s_valid = 1'b0;
    s_data = '0;
    pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_vals("por");
    reset = 1'b0;

    // start requests from IDLE; a word is offered but must not be taken
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data = 32'hDEADBEEF;
      start = 1'b1;
      load_len = tbl[i].len;
      tick();
      start = 1'b0;
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 0);
      chk($sformatf("tbl%0d_cpu_reset", i), 32'(cpu_reset), 1);
      tick();
      chk($sformatf("tbl%0d_s_ready2", i), 32'(s_ready),
          32'(tbl[i].e_rdy2));
      if (tbl[i].e_busy) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    s_valid = 1'b0;

    do_load(7'd3, -1, 0, 5, "load3", 0);
    do_load(7'd3, 2, 2, 7, "gap", 0);

    // pc settles at 8 for 3 compares, moves to 0xC, then stays there
    pc = 32'h8;
    repeat (4) tick();
    pc = 32'hC;
    tick();
    tick();
    chk("nohalt_early", 32'(halted), 0);
    chk("nohalt_running", 32'(running), 1);
    repeat (3) tick();
    chk("nohalt_before", 32'(halted), 0);
    tick();
`ifdef BOOT_HALT_DETECT_EN
    chk("halt_halted", 32'(halted), 1);
    chk("halt_cpu_reset", 32'(cpu_reset), 1);
    chk("halt_running", 32'(running), 0);
`else
    chk("nodet_halted", 32'(halted), 0);
    chk("nodet_cpu_reset", 32'(cpu_reset), 0);
    chk("nodet_running", 32'(running), 1);
`endif

    // invalid request sets err without leaving the current state
    start = 1'b1;
    load_len = 7'd0;
    tick();
    start = 1'b0;
    chk("bad_start_err", 32'(err), 1);
    chk("bad_start_busy", 32'(busy), 0);
`ifdef BOOT_HALT_DETECT_EN
    chk("bad_start_halted", 32'(halted), 1);
`else
    chk("bad_start_running", 32'(running), 1);
`endif

    pc = '0;
    do_load(7'd2, -1, 0, 4, "reload", 3);
    chk("reload_err_cleared", 32'(err), 0);

    // reset after 2 of 4 words
    start = 1'b1;
    load_len = 7'd4;
    tick();
    start = 1'b0;
    w = 0;
    lat = 0;
    a = '0;
    while (w < 2 && lat < 50) begin
      s_valid = 1'b1;
      s_data = prog[w];
      if (s_ready) begin
        e.addr = a;
        e.data = s_data;
        exp_q.push_back(e);
        a++;
        w++;
      end
      tick();
      lat++;
    end
    s_valid = 1'b0;
    chk("midload_words", w, 2);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    rst_vals("midload_rst");
    chk("midload_pending", exp_q.size(), 0);
    reset = 1'b0;

    do_load(7'd3, -1, 0, 5, "restart", 0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
